// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of an async FIFO with a FWFT output register
// Ports:
//   rclk, rrst_n      read clock, async active-low reset
//   wptr_gray         write-domain Gray pointer (asynchronous, 2-flop synced)
//   raddr, mem_rdata  read address to / combinational data from FIFO memory
//   rptr_gray         registered Gray read pointer for the write-side full logic
//   rdata, rvalid     FWFT output word and its valid flag
//   rready            consumer accepts rdata this cycle
//   rempty            registered !rvalid
//   rlevel            words held in memory plus the output register
//   ralmost_empty     rlevel <= AE_THRESH
module fifo_rd_ctrl #(
  parameter int n         = 4,
  parameter int DATA      = 8,
  parameter int DEPTH     = 16,
  parameter int AE_THRESH = 2
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic [n:0]      wptr_gray,
  output logic [n-1:0]    raddr,
  input  logic [DATA-1:0] mem_rdata,
  output logic [n:0]      rptr_gray,
  output logic [DATA-1:0] rdata,
  output logic            rvalid,
  input  logic            rready,
  output logic            rempty,
  output logic [n:0]      rlevel,
  output logic            ralmost_empty
);
  logic [n:0]      wq1_q, wq2_q, rbin_q, rbin_d, rgray_q, wbin_s, mem_level;
  logic [DATA-1:0] rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d, rempty_q, fetch;

  function automatic logic [n:0] gray2bin(input logic [n:0] g);
    logic [n:0] b;
    b = g;
    for (int i = 1; i <= n; i++) b = b ^ (g >> i);
    return b;
  endfunction

  assign wbin_s    = gray2bin(wq2_q);
  // modulo 2**(n+1) subtraction keeps the level correct across pointer wrap
  assign mem_level = wbin_s - rbin_q;
  // refill the output register when it is empty or being drained this cycle
  assign fetch     = (mem_level != '0) && (!rvalid_q || rready);
  assign rbin_d    = fetch ? rbin_q + 1'b1 : rbin_q;
  assign rdata_d   = fetch ? mem_rdata : rdata_q;
  assign rvalid_d  = fetch || (rvalid_q && !rready);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1_q    <= '0;
      wq2_q    <= '0;
      rbin_q   <= '0;
      rgray_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rempty_q <= 1'b1;
    end else begin
      wq1_q    <= wptr_gray;
      wq2_q    <= wq1_q;
      rbin_q   <= rbin_d;
      rgray_q  <= rbin_d ^ (rbin_d >> 1);
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rempty_q <= !rvalid_d;
    end
  end

  assign raddr         = rbin_q[$clog2(DEPTH)-1:0];
  assign rptr_gray     = rgray_q;
  assign rdata         = rdata_q;
  assign rvalid        = rvalid_q;
  assign rempty        = rempty_q;
  assign rlevel        = mem_level + {{n{1'b0}}, rvalid_q};
  assign ralmost_empty = int'(rlevel) <= AE_THRESH;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed and randomized checks of the FIFO read controller
module tb_fifo_rd_ctrl;
  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] wptr_gray;
  logic [3:0] raddr;
  logic [7:0] mem_rdata;
  logic [4:0] rptr_gray;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       rempty;
  logic [4:0] rlevel;
  logic       ralmost_empty;

  logic [7:0] mem [16];
  logic [4:0] wbin;
  logic [7:0] q[$];
  int checks = 0;
  int failures = 0;

  always #5 rclk = ~rclk;
  assign mem_rdata = mem[raddr];

  fifo_rd_ctrl #(.n(4), .DATA(8), .DEPTH(16), .AE_THRESH(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .wptr_gray(wptr_gray), .raddr(raddr),
    .mem_rdata(mem_rdata), .rptr_gray(rptr_gray), .rdata(rdata), .rvalid(rvalid),
    .rready(rready), .rempty(rempty), .rlevel(rlevel), .ralmost_empty(ralmost_empty)
  );

  task automatic tick;
    @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    mem[wbin[3:0]] = d;
    wbin = wbin + 5'd1;
    wptr_gray = wbin ^ (wbin >> 1);
    q.push_back(d);
  endtask

  task automatic do_reset;
    rrst_n = 1'b0;
    rready = 1'b0;
    wbin = '0;
    wptr_gray = '0;
    q.delete();
    @(negedge rclk);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  task automatic test_reset;
    rrst_n = 1'b0;
    rready = 1'b0;
    wbin = '0;
    wptr_gray = '0;
    #12;
    checks++;
    if (rempty !== 1'b1 || rvalid !== 1'b0 || rlevel !== 5'd0 || ralmost_empty !== 1'b1 ||
        rptr_gray !== 5'd0 || raddr !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: rempty=%b rvalid=%b rlevel=%0d ae=%b rptr_gray=%h raddr=%0d, required 1 0 0 1 00 0",
               rempty, rvalid, rlevel, ralmost_empty, rptr_gray, raddr);
    end
    @(negedge rclk);
    rrst_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    repeat (3) tick();
    checks++;
    if (rvalid !== 1'b1 || rlevel !== 5'd5 || rptr_gray !== 5'd1) begin
      failures++;
      $display("FAIL pre_reset_fill: rvalid=%b rlevel=%0d rptr_gray=%h, required 1 5 01", rvalid, rlevel, rptr_gray);
    end
    #2 rrst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || rempty !== 1'b1 || rlevel !== 5'd0 || rptr_gray !== 5'd0) begin
      failures++;
      $display("FAIL mid_reset: rvalid=%b rempty=%b rlevel=%0d rptr_gray=%h, required 0 1 0 00", rvalid, rempty, rlevel, rptr_gray);
    end
    do_reset();
  endtask

  task automatic test_latency;
    tick();
    push(8'hA5);
    tick();
    tick();
    checks++;
    if (rvalid !== 1'b0) begin
      failures++;
      $display("FAIL latency_edge2: rvalid=%b, required 0", rvalid);
    end
    tick();
    checks++;
    if (rvalid !== 1'b1 || rdata !== 8'hA5 || rempty !== 1'b0) begin
      failures++;
      $display("FAIL latency_edge3: rvalid=%b rdata=%h rempty=%b, required 1 a5 0", rvalid, rdata, rempty);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (rvalid !== 1'b1 || rdata !== 8'hA5 || rlevel !== 5'd1) begin
        failures++;
        $display("FAIL hold_%0d: rvalid=%b rdata=%h rlevel=%0d, required 1 a5 1", i, rvalid, rdata, rlevel);
      end
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0 || rempty !== 1'b1 || rlevel !== 5'd0 || rdata !== 8'hA5) begin
      failures++;
      $display("FAIL single_consume: rvalid=%b rempty=%b rlevel=%0d rdata=%h, required 0 1 0 a5", rvalid, rempty, rlevel, rdata);
    end
  endtask

  task automatic test_full;
    do_reset();
    tick();
    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    rready = 1'b1;
    tick();
    tick();
    checks++;
    if (rlevel !== 5'd16 || rvalid !== 1'b0 || ralmost_empty !== 1'b0) begin
      failures++;
      $display("FAIL full_level: rlevel=%0d rvalid=%b ae=%b, required 16 0 0", rlevel, rvalid, ralmost_empty);
    end
    tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL full_word_%0d: rvalid=%b rdata=%h, required 1 %h", i, rvalid, rdata, 8'h10 + 8'(i));
      end
      tick();
    end
    checks++;
    if (rvalid !== 1'b0 || rempty !== 1'b1 || rptr_gray !== 5'h18 || rlevel !== 5'd0) begin
      failures++;
      $display("FAIL full_drained: rvalid=%b rempty=%b rptr_gray=%h rlevel=%0d, required 0 1 18 0", rvalid, rempty, rptr_gray, rlevel);
    end
    q.delete();
  endtask

  task automatic test_wrap;
    int pushed = 0;
    int consumed = 0;
    logic [4:0] prev_g;
    prev_g = rptr_gray;
    rready = 1'b1;
    for (int c = 0; c < 300 && consumed < 40; c++) begin
      if (pushed < 40 && q.size() < 16) begin
        push(8'($urandom));
        pushed++;
      end
      if (rvalid) begin
        checks++;
        if (rdata !== q[0]) begin
          failures++;
          $display("FAIL wrap_data_%0d: rdata=%h, required %h", consumed, rdata, q[0]);
        end
        void'(q.pop_front());
        consumed++;
      end
      tick();
      if (rptr_gray !== prev_g) begin
        checks++;
        if ($countones(rptr_gray ^ prev_g) != 1) begin
          failures++;
          $display("FAIL wrap_gray_step: %h -> %h, required a 1-bit change", prev_g, rptr_gray);
        end
        prev_g = rptr_gray;
      end
    end
    checks++;
    if (consumed != 40) begin
      failures++;
      $display("FAIL wrap_timeout: consumed=%0d, required 40", consumed);
    end
    tick();
    checks++;
    if (rptr_gray !== 5'h14 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_final: rptr_gray=%h rvalid=%b, required 14 0", rptr_gray, rvalid);
    end
  endtask

  task automatic test_ae;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    tick();
    tick();
    tick();
    checks++;
    if (rvalid !== 1'b1 || rlevel !== 5'd4 || ralmost_empty !== 1'b0) begin
      failures++;
      $display("FAIL ae_level4: rvalid=%b rlevel=%0d ae=%b, required 1 4 0", rvalid, rlevel, ralmost_empty);
    end
    rready = 1'b1;
    tick();
    checks++;
    if (rlevel !== 5'd3 || ralmost_empty !== 1'b0 || rdata !== 8'h51) begin
      failures++;
      $display("FAIL ae_level3: rlevel=%0d ae=%b rdata=%h, required 3 0 51", rlevel, ralmost_empty, rdata);
    end
    tick();
    rready = 1'b0;
    checks++;
    if (rlevel !== 5'd2 || ralmost_empty !== 1'b1 || rdata !== 8'h52) begin
      failures++;
      $display("FAIL ae_level2: rlevel=%0d ae=%b rdata=%h, required 2 1 52", rlevel, ralmost_empty, rdata);
    end
    rready = 1'b1;
    tick();
    tick();
    checks++;
    if (rvalid !== 1'b0 || rlevel !== 5'd0 || ralmost_empty !== 1'b1) begin
      failures++;
      $display("FAIL ae_drain: rvalid=%b rlevel=%0d ae=%b, required 0 0 1", rvalid, rlevel, ralmost_empty);
    end
    repeat (3) tick();
    checks++;
    if (rptr_gray !== 5'h06 || raddr !== 4'd4 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL underflow: rptr_gray=%h raddr=%0d rvalid=%b, required 06 4 0", rptr_gray, raddr, rvalid);
    end
    rready = 1'b0;
    q.delete();
  endtask

  task automatic test_random;
    int pushed = 0;
    int consumed = 0;
    logic [7:0] held;
    logic stall;
    for (int c = 0; c < 3000 && consumed < 60; c++) begin
      if (pushed < 60 && q.size() < 16 && $urandom_range(1, 0) == 1) begin
        push(8'($urandom));
        pushed++;
      end
      rready = $urandom_range(1, 0) == 1;
      stall = rvalid && !rready;
      held = rdata;
      if (rvalid && rready) begin
        checks++;
        if (rdata !== q[0]) begin
          failures++;
          $display("FAIL rand_data_%0d: rdata=%h, required %h", consumed, rdata, q[0]);
        end
        void'(q.pop_front());
        consumed++;
      end
      tick();
      if (stall) begin
        checks++;
        if (rvalid !== 1'b1 || rdata !== held) begin
          failures++;
          $display("FAIL rand_stall: rvalid=%b rdata=%h, required 1 %h", rvalid, rdata, held);
        end
      end
      checks++;
      if (int'(rlevel) > q.size() || rempty !== !rvalid) begin
        failures++;
        $display("FAIL rand_level: rlevel=%0d rempty=%b rvalid=%b, required rlevel<=%0d and rempty=!rvalid",
                 rlevel, rempty, rvalid, q.size());
      end
    end
    checks++;
    if (consumed != 60) begin
      failures++;
      $display("FAIL rand_timeout: consumed=%0d, required 60", consumed);
    end
    rready = 1'b1;
    repeat (4) tick();
    checks++;
    if (rvalid !== 1'b0 || rlevel !== 5'd0) begin
      failures++;
      $display("FAIL rand_extra_word: rvalid=%b rlevel=%0d, required 0 0", rvalid, rlevel);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    test_reset();
    test_latency();
    test_full();
    test_wrap();
    test_ae();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
